// File: rtl/sdram_port_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_port_pkg                                                        |
// | FSM state type and default geometry for the SDRAM user port.          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package sdram_port_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_INIT_CYCLES = 200;

endpackage
`default_nettype wire

// File: rtl/sdram_user_port_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_user_port_if                                                    |
// | Streaming word bus between test master and SDRAM user port.           |
// | err_inject exists only when SDRAM_PORT_ERR_INJECT_EN is defined.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface sdram_user_port_if
  import sdram_port_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              sdram_init_done;
  logic              cmd_err;
  logic              mem_filled;
`ifdef SDRAM_PORT_ERR_INJECT_EN
  logic              err_inject;
`endif

  modport master (
`ifdef SDRAM_PORT_ERR_INJECT_EN
    output err_inject,
`endif
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, sdram_init_done, cmd_err, mem_filled
  );

  modport slave (
`ifdef SDRAM_PORT_ERR_INJECT_EN
    input  err_inject,
`endif
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, sdram_init_done, cmd_err, mem_filled
  );

endinterface
`default_nettype wire

// File: rtl/sdram_port_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_port_ram                                                        |
// | Simple dual-port RAM, registered read port, read-before-write.        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sdram_port_ram
  import sdram_port_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_we,
  input  wire logic [ADDR_W-1:0] i_waddr,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic              i_re,
  input  wire logic [ADDR_W-1:0] i_raddr,
  output logic      [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Array is deliberately left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_user_port.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_user_port                                                       |
// | Init-delayed streaming word responder backed by a dual-port RAM.      |
// | Optional: SDRAM_PORT_ERR_INJECT_EN adds single-shot bit-0 corruption. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sdram_user_port
  import sdram_port_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES
) (
  input  wire logic        clk_50m,
  input  wire logic        reset,
  sdram_user_port_if.slave bus
);

  localparam int            CW          = $clog2(INIT_CYCLES + 1);
  localparam logic [CW-1:0] c_init_last = CW'(INIT_CYCLES - 1);

  state_t            r_state;
  logic [CW-1:0]     r_init_cnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_valid;
  logic              r_init_done;
  logic              r_cmd_err;
  logic              r_mem_filled;

  logic              w_ready;
  logic              w_wr_go;
  logic              w_rd_go;
  logic [DATA_W-1:0] w_ram_q;

  assign w_ready = (r_state == READY);
  assign w_wr_go = w_ready & bus.wr_en & ~reset;
  assign w_rd_go = w_ready & bus.rd_en & ~reset;

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      r_state      <= INIT;
      r_init_cnt   <= '0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_rd_valid   <= 1'b0;
      r_init_done  <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_mem_filled <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        INIT: begin
          if (bus.wr_en || bus.rd_en) begin
            r_cmd_err <= 1'b1;
          end
          if (r_init_cnt == c_init_last) begin
            r_state     <= READY;
            r_init_done <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + CW'(1);
          end
        end
        READY: begin
          if (bus.wr_en) begin
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
            if (r_wr_addr == {ADDR_W{1'b1}}) begin
              r_mem_filled <= 1'b1;
            end
          end
          if (bus.rd_en) begin
            r_rd_addr  <= r_rd_addr + ADDR_W'(1);
            r_rd_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= INIT;
        end
      endcase
    end
  end

  sdram_port_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_50m),
    .rst     (reset),
    .i_we    (w_wr_go),
    .i_waddr (r_wr_addr),
    .i_wdata (bus.wr_data),
    .i_re    (w_rd_go),
    .i_raddr (r_rd_addr),
    .o_rdata (w_ram_q)
  );

`ifdef SDRAM_PORT_ERR_INJECT_EN
  logic r_inj_pend;
  logic r_inj_flip;

  // A pulse landing on the consuming read re-arms for the following read.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      r_inj_pend <= 1'b0;
      r_inj_flip <= 1'b0;
    end else begin
      if (w_rd_go) begin
        r_inj_flip <= r_inj_pend;
        r_inj_pend <= 1'b0;
      end
      if (bus.err_inject) begin
        r_inj_pend <= 1'b1;
      end
    end
  end

  assign bus.rd_data = w_ram_q ^ {{(DATA_W-1){1'b0}}, r_inj_flip};
`else
  assign bus.rd_data = w_ram_q;
`endif

  assign bus.rd_valid        = r_rd_valid;
  assign bus.sdram_init_done = r_init_done;
  assign bus.cmd_err         = r_cmd_err;
  assign bus.mem_filled      = r_mem_filled;

endmodule
`default_nettype wire

// File: tb/tb_sdram_user_port.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sdram_user_port                                                    |
// | Scoreboard bench for sdram_user_port against a word-level model.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_sdram_user_port;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int IC    = 200;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    bit          known;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   tb_inj = 1'b0;

  sdram_user_port_if #(.DATA_W(DW)) bus_if ();

  sdram_user_port #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .INIT_CYCLES (IC)
  ) dut (
    .clk_50m (clk),
    .reset   (rst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  int          since;
  int          wp, rp;
  bit          e_err, e_fill, e_valid, pend;
  logic [15:0] last_val;
  bit          last_known;
  exp_t        sb[$];

  int  n_cmp = 0;
  int  n_mis = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    exp_t e;
    bit   srv;
    if (rst) begin
      since = 0; wp = 0; rp = 0;
      e_err = 0; e_fill = 0; e_valid = 0; pend = 0;
      last_val = '0; last_known = 1;
      sb.delete();
    end else begin
      since++;
      srv = (since > IC);
      e_valid = 0;
      if (!srv && (bus_if.wr_en || bus_if.rd_en)) e_err = 1;
      if (srv && bus_if.rd_en) begin
        e.known = m_known[rp];
        e.val   = m_mem[rp] ^ {15'd0, pend};
        sb.push_back(e);
        rp = (rp + 1) % DEPTH;
        pend = 0;
        e_valid = 1;
      end
      if (tb_inj) pend = 1;
      if (srv && bus_if.wr_en) begin
        m_mem[wp]   = bus_if.wr_data;
        m_known[wp] = 1;
        if (wp == DEPTH - 1) e_fill = 1;
        wp = (wp + 1) % DEPTH;
      end
    end
  endtask

  task automatic drive(input bit r, input bit w, input logic [15:0] d, input bit rd, input bit inj);
    exp_t e;
    rst            = r;
    bus_if.wr_en   = w;
    bus_if.wr_data = d;
    bus_if.rd_en   = rd;
`ifdef SDRAM_PORT_ERR_INJECT_EN
    bus_if.err_inject = inj;
    tb_inj = inj;
`else
    tb_inj = 1'b0;
`endif
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 16'h0, 0, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read word
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("init_done", {31'd0, bus_if.sdram_init_done}, {31'd0, (since >= IC)});
      chk("cmd_err", {31'd0, bus_if.cmd_err}, {31'd0, e_err});
      chk("mem_filled", {31'd0, bus_if.mem_filled}, {31'd0, e_fill});
      chk("rd_valid", {31'd0, bus_if.rd_valid}, {31'd0, e_valid});
      if (bus_if.rd_valid) begin
        if (sb.size() == 0) begin
          chk("rd_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.known) chk("rd_data", {16'd0, bus_if.rd_data}, {16'd0, e.val});
          last_val   = e.val;
          last_known = e.known;
        end
      end else begin
        sb.delete();
        if (last_known) chk("rd_hold", {16'd0, bus_if.rd_data}, {16'd0, last_val});
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    bus_if.wr_en = 0; bus_if.wr_data = '0; bus_if.rd_en = 0;
`ifdef SDRAM_PORT_ERR_INJECT_EN
    bus_if.err_inject = 0;
`endif
    drive(1, 0, 16'h0, 0, 0);
    drive(1, 0, 16'h0, 0, 0);
    mon_en = 1'b1;

    // Init delay with idle bus
    idle(IC + 3);

    // Fill 1..1024 then stream 2048 reads
    for (int i = 1; i <= DEPTH; i++) drive(0, 1, 16'(i), 0, 0);
    chk("filled_after_fill", {31'd0, bus_if.mem_filled}, 32'd1);
    for (int i = 0; i < 2 * DEPTH; i++) drive(0, 0, 16'h0, 1, 0);
    idle(2);

    // Write during INIT is ignored and flagged
    drive(1, 0, 16'h0, 0, 0);
    drive(0, 1, 16'hABCD, 0, 0);
    idle(IC);
    drive(0, 0, 16'h0, 1, 0);
    chk("init_write_ignored", {31'd0, (bus_if.rd_data != 16'hABCD)}, 32'd1);
    idle(2);

    // Read-before-write collision at address 5
    drive(1, 0, 16'h0, 0, 0);
    idle(IC + 1);
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 16'(i), 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 16'h0, 1, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 16'(i), 0, 0);
    drive(0, 1, 16'h1234, 1, 0);
    chk("rbw_old", {16'd0, bus_if.rd_data}, 32'h0005);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 16'h0, 1, 0);
    chk("rbw_new", {16'd0, bus_if.rd_data}, 32'h1234);
    idle(2);

`ifdef SDRAM_PORT_ERR_INJECT_EN
    // Two inject pulses arm a single corruption
    drive(1, 0, 16'h0, 0, 0);
    idle(IC + 1);
    drive(0, 1, 16'h0010, 0, 0);
    drive(0, 1, 16'h0011, 0, 0);
    drive(0, 0, 16'h0, 0, 1);
    idle(1);
    drive(0, 0, 16'h0, 0, 1);
    drive(0, 0, 16'h0, 1, 0);
    chk("inject_first", {16'd0, bus_if.rd_data}, 32'h0011);
    drive(0, 0, 16'h0, 1, 0);
    chk("inject_second", {16'd0, bus_if.rd_data}, 32'h0011);
    idle(2);
`endif

    // Reset in the middle of a read stream
    for (int i = 0; i < 20; i++) drive(0, 0, 16'h0, 1, 0);
    drive(1, 0, 16'h0, 1, 0);
    chk("reset_rd_valid", {31'd0, bus_if.rd_valid}, 32'd0);
    for (int i = 0; i < IC + 10; i++) drive(0, 0, 16'h0, 1, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom_range(0, 399) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_user_port.md
SDRAM_USER_PORT -- requirements
Module: sdram_user_port

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports: clk_50m  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL have parameters: DATA_W, default 16, data width; ADDR_W, default 10, word address width; INIT_CYCLES, default 200, power-up init delay in clocks.
REQ-003 The block SHALL have ports: wr_en  in  1  write one word this cycle; wr_data  in  DATA_W  write word; rd_en  in  1  read one word this cycle.
REQ-004 The block SHALL have ports: rd_data  out  DATA_W  registered read word; rd_valid  out  1  rd_data valid this cycle; sdram_init_done  out  1  port ready.
REQ-005 The block SHALL have ports: cmd_err  out  1  sticky access-before-ready flag; mem_filled  out  1  all 2^ADDR_W words written at least once.
REQ-006 When SDRAM_PORT_ERR_INJECT_EN is defined, the block SHALL have port: err_inject  in  1  corrupt next read word.

Function
REQ-007 The block SHALL implement a responder for a streaming test master, with an FSM of states INIT and READY.
REQ-008 INIT SHALL count to INIT_CYCLES-1, then enter READY; sdram_init_done SHALL be 1 exactly in READY, registered.
REQ-009 Write addressing: in READY with wr_en=1, the block SHALL store mem[wr_addr]<=wr_data and increment wr_addr, wrapping 2^ADDR_W-1 -> 0.
REQ-010 Read addressing: in READY with rd_en=1, the block SHALL set rd_data<=mem[rd_addr] and rd_valid<=1 at that same edge (latency 1), then increment rd_addr with the same wrap.
REQ-011 When rd_en=0, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-012 Simultaneous wr_en and rd_en SHALL both be serviced; when addresses are equal, the read SHALL return the old contents (read-before-write).
REQ-013 wr_en or rd_en in INIT SHALL be ignored: no memory or address change, rd_valid=0, and cmd_err<=1 (sticky until reset).
REQ-014 mem_filled SHALL set on the write to address 2^ADDR_W-1 and stay set until reset; wrapping the write address SHALL NOT clear it.
REQ-015 Memory contents are not reset; a read before any write to that address returns unspecified data, and this is not an error.

Reset
REQ-016 reset=1 at a clock edge SHALL force: state INIT, init counter 0, wr_addr 0, rd_addr 0, rd_data 0, rd_valid 0, sdram_init_done 0, cmd_err 0, mem_filled 0, pending inject 0.
REQ-017 A reset mid-stream SHALL abandon any access on that edge and restart the full INIT_CYCLES delay.

Configuration
REQ-018 With SDRAM_PORT_ERR_INJECT_EN defined, an err_inject pulse SHALL arm one pending corruption, and the next serviced read SHALL return rd_data with bit 0 inverted and clear the pending corruption.
REQ-019 Further err_inject pulses while a corruption is pending SHALL NOT stack.
REQ-020 Without SDRAM_PORT_ERR_INJECT_EN, the err_inject port and its logic SHALL be absent and reads SHALL be exact.

Structure
REQ-021 Package sdram_port_pkg SHALL hold the FSM state typedef (INIT, READY) and the default width/depth constants.
REQ-022 Storage SHALL be a sub-module sdram_port_ram: simple dual-port, one write port and one registered read port, read-before-write; the FSM, address counters and flags SHALL stay in sdram_user_port.

Verification
REQ-023 Bench: reset, then idle -> sdram_init_done rises exactly INIT_CYCLES clocks after reset deasserts; cmd_err=0.
REQ-024 Bench: write 1..1024 on consecutive cycles, then hold rd_en=1 for 2048 cycles -> rd_valid from the 2nd cycle; rd_data sequence 1..1024 repeated twice; mem_filled=1 after the 1024th write.
REQ-025 Bench: wr_en=1 during INIT with wr_data=0xABCD -> cmd_err=1; a later read of address 0 does not return 0xABCD.
REQ-026 Bench: write address 5 = 0x0005 and, in the same cycle, read address 5 while writing 0x1234 -> read returns 0x0005; the next pass returns 0x1234.
REQ-027 Bench (macro defined): err_inject pulsed twice, then two reads of 0x0010 and 0x0011 -> 0x0011 then 0x0011.
REQ-028 Bench: reset asserted mid-read-stream -> rd_valid=0 next cycle, addresses 0, sdram_init_done low for INIT_CYCLES clocks.
